// File: rtl/odliczanie_pkg.sv
// Shared constants, FSM state type and the mod-720 angle helper for the crank-angle timebase.
package odliczanie_pkg;

    localparam int unsigned KAT_CYKLU = 720;
    localparam int unsigned SZER_KATA = 10;
    localparam logic [SZER_KATA:0] KAT_CYKLU_W = 11'd720;

    typedef enum logic {STOP, RUN} stan_e;

    // kat + dopelnienie stays below 1440, so one conditional subtract reduces it mod 720.
    function automatic logic [SZER_KATA-1:0] kat_przesuniety(
        input logic [SZER_KATA-1:0] kat,
        input logic [SZER_KATA:0]   dopelnienie
    );
        logic [SZER_KATA:0] suma;
        suma = {1'b0, kat} + dopelnienie;
        if (suma >= KAT_CYKLU_W) begin
            suma = suma - KAT_CYKLU_W;
        end
        return suma[SZER_KATA-1:0];
    endfunction

endpackage

// File: rtl/preskaler_stopni.sv
// Clock-to-degree prescaler. The shadow period is retimed into the active period only on
// run entry or at a degree boundary.
module preskaler_stopni #(
    parameter int unsigned SZER_TAKT = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 liczy_i,
    input  logic                 strobe_i,
    input  logic [SZER_TAKT-1:0] okres_i,
    output logic                 tik_o,
    output logic                 shadow_niezerowy_o
);

    localparam logic [SZER_TAKT-1:0] JEDEN = {{(SZER_TAKT-1){1'b0}}, 1'b1};

    logic [SZER_TAKT-1:0] shadow_q, shadow_d;
    logic [SZER_TAKT-1:0] aktywny_q, aktywny_d;
    logic [SZER_TAKT-1:0] licznik_q, licznik_d;
    logic                 koniec;

    assign koniec             = (licznik_q == (aktywny_q - JEDEN));
    assign tik_o              = liczy_i && koniec;
    assign shadow_niezerowy_o = (shadow_q != '0);

    always_comb begin
        shadow_d  = shadow_q;
        aktywny_d = aktywny_q;
        licznik_d = licznik_q;
        if (strobe_i && (okres_i != '0)) begin
            shadow_d = okres_i;
        end
        // Loads read shadow_q, so a coincident strobe only takes effect one degree later.
        if (start_i) begin
            aktywny_d = shadow_q;
            licznik_d = '0;
        end else if (liczy_i) begin
            if (koniec) begin
                licznik_d = '0;
                aktywny_d = shadow_q;
            end else begin
                licznik_d = licznik_q + JEDEN;
            end
        end else begin
            licznik_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q  <= '0;
            aktywny_q <= '0;
            licznik_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            aktywny_q <= aktywny_d;
            licznik_q <= licznik_d;
        end
    end

endmodule

// File: rtl/odliczanie_wielocylindrowe.sv
// N-cylinder crank-angle timebase: 720-degree cycle counter, phase-shifted cylinder angles,
// per-cylinder revolution counters and ignition pulses at a programmable advance.
module odliczanie_wielocylindrowe
    import odliczanie_pkg::*;
#(
    parameter int unsigned LICZBA_CYLINDROW = 2,
    parameter int unsigned SZER_TAKT        = 9,
    parameter int unsigned SZER_OBROTOW     = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   rozruch,
    input  logic                                   sygnal_zmiany_rpm,
    input  logic [SZER_TAKT-1:0]                   taktowanie_na_stopien,
    input  logic [9:0]                             wyprzedzenie,
    output logic [LICZBA_CYLINDROW*SZER_KATA-1:0]  kat_cylindra,
    output logic [LICZBA_CYLINDROW*SZER_OBROTOW-1:0] zliczanie_obrotow,
    output logic [LICZBA_CYLINDROW-1:0]            iskra,
    output logic                                   pracuje
);

    localparam logic [SZER_OBROTOW-1:0] OBR_JEDEN = {{(SZER_OBROTOW-1){1'b0}}, 1'b1};

    stan_e                stan_q, stan_d;
    logic [SZER_KATA-1:0] kat_q, kat_d;
    logic                 pracuje_q, pracuje_d;
    logic                 start, liczy, tik, shadow_niezerowy;
    logic                 iskra_dozwolona;
    logic [SZER_KATA-1:0] kat_iskry;

    assign start = (stan_q == STOP) && rozruch && shadow_niezerowy;
    assign liczy = (stan_q == RUN) && rozruch;

    preskaler_stopni #(
        .SZER_TAKT (SZER_TAKT)
    ) u_preskaler (
        .clk                (clk),
        .reset              (reset),
        .start_i            (start),
        .liczy_i            (liczy),
        .strobe_i           (sygnal_zmiany_rpm),
        .okres_i            (taktowanie_na_stopien),
        .tik_o              (tik),
        .shadow_niezerowy_o (shadow_niezerowy)
    );

    // An advance of 0 would give 720, which must fold back to angle 0.
    always_comb begin
        iskra_dozwolona = (wyprzedzenie <= 10'd719);
        kat_iskry       = '0;
        if (wyprzedzenie != 10'd0) begin
            kat_iskry = SZER_KATA'(KAT_CYKLU_W - {1'b0, wyprzedzenie});
        end
    end

    always_comb begin
        stan_d = stan_q;
        kat_d  = kat_q;
        unique case (stan_q)
            STOP: begin
                kat_d = '0;
                if (start) begin
                    stan_d = RUN;
                end
            end
            RUN: begin
                if (!rozruch) begin
                    stan_d = STOP;
                    kat_d  = '0;
                end else if (tik) begin
                    kat_d = (kat_q == 10'd719) ? '0 : kat_q + 10'd1;
                end
            end
            default: begin
                stan_d = STOP;
                kat_d  = '0;
            end
        endcase
        pracuje_d = (stan_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stan_q    <= STOP;
            kat_q     <= '0;
            pracuje_q <= 1'b0;
        end else begin
            stan_q    <= stan_d;
            kat_q     <= kat_d;
            pracuje_q <= pracuje_d;
        end
    end

    assign pracuje = pracuje_q;

    for (genvar k = 0; k < LICZBA_CYLINDROW; k++) begin : g_cyl
        localparam int unsigned       PRZES  = k * KAT_CYKLU / LICZBA_CYLINDROW;
        localparam logic [SZER_KATA:0] DOPELN = (SZER_KATA + 1)'(KAT_CYKLU - PRZES);

        logic [SZER_KATA-1:0]    kat_c_q, kat_c_d;
        logic [SZER_OBROTOW-1:0] obr_q, obr_d;
        logic                    iskra_q, iskra_d;

        // Counters are already zero on entry because STOP holds them cleared.
        always_comb begin
            kat_c_d = '0;
            obr_d   = '0;
            iskra_d = 1'b0;
            if (stan_d == RUN) begin
                kat_c_d = kat_przesuniety(kat_d, DOPELN);
                obr_d   = obr_q;
                if (tik) begin
                    if ((kat_c_d == 10'd0) || (kat_c_d == 10'd360)) begin
                        obr_d = obr_q + OBR_JEDEN;
                    end
                    iskra_d = iskra_dozwolona && (kat_c_d == kat_iskry);
                end
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                kat_c_q <= '0;
                obr_q   <= '0;
                iskra_q <= 1'b0;
            end else begin
                kat_c_q <= kat_c_d;
                obr_q   <= obr_d;
                iskra_q <= iskra_d;
            end
        end

        assign kat_cylindra[SZER_KATA*k +: SZER_KATA]            = kat_c_q;
        assign zliczanie_obrotow[SZER_OBROTOW*k +: SZER_OBROTOW] = obr_q;
        assign iskra[k]                                          = iskra_q;
    end

endmodule
